// File: rtl/fb_pkg.sv
// Shared types and helpers for the ping-pong frame buffer.
package fb_pkg;
    typedef enum logic {FILL, DONE} fb_state_e;

    localparam int READ_LATENCY = 3;

    function automatic logic [23:0] rgb565_to_rgb888(input logic [15:0] p);
        return {p[15:11], 3'b0, p[10:5], 2'b0, p[4:0], 3'b0};
    endfunction
endpackage

// File: rtl/fb_read_addr_gen.sv
// Stage 0 of the read pipeline: downscaled address, active bit and display buffer.
module fb_read_addr_gen
    import fb_pkg::*;
#(
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int SCALE_SHIFT   = 2,
    parameter int ADDR_W        = 16
) (
    input  logic              pixel_clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              sel,
    input  logic              shown,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_active,
    output logic              rd_buf
);
    localparam int VIS_W = SCREEN_WIDTH << SCALE_SHIFT;
    localparam int VIS_H = SCREEN_HEIGHT << SCALE_SHIFT;

    logic [10:0]       x;
    logic [9:0]        y;
    logic [ADDR_W-1:0] addr_c;
    logic              active_c;

    assign x        = hcount_in >> SCALE_SHIFT;
    assign y        = vcount_in >> SCALE_SHIFT;
    assign addr_c   = ADDR_W'(int'(x) + SCREEN_WIDTH * int'(y));
    assign active_c = (int'(hcount_in) < VIS_W) && (int'(vcount_in) < VIS_H);

    // Gating with shown here keeps the never-written buffer off the screen.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            rd_addr   <= '0;
            rd_active <= 1'b0;
            rd_buf    <= 1'b1;
        end else begin
            rd_addr   <= addr_c;
            rd_active <= active_c & shown;
            rd_buf    <= ~sel;
        end
    end
endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// Single-port read-first block RAM with optional output register.
module xilinx_single_port_ram_read_first #(
    parameter int RAM_WIDTH       = 18,
    parameter int RAM_DEPTH       = 1024,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE"
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic [RAM_WIDTH-1:0]         douta
);
    logic [RAM_WIDTH-1:0] ram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_data;

    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) ram[addra] <= dina;
            ram_data <= ram[addra];
        end
    end

    generate
        if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
            assign douta = ram_data;
        end else begin : g_out_reg
            always_ff @(posedge clka) begin
                if (rsta)        douta <= '0;
                else if (regcea) douta <= ram_data;
            end
        end
    endgenerate
endmodule

// File: rtl/pingpong_frame_buffer.sv
// Double-buffered frame store: writer fills buffer sel, video scans !sel, swap at frame end.
module pingpong_frame_buffer
    import fb_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 16,
    parameter int SCREEN_WIDTH  = 320,
    parameter int SCREEN_HEIGHT = 180,
    parameter int SCALE_SHIFT   = 2,
    localparam int DEPTH        = SCREEN_WIDTH * SCREEN_HEIGHT,
    localparam int ADDR_W       = $clog2(DEPTH)
) (
    input  logic                   pixel_clk_in,
    input  logic                   rst_in,
    input  logic                   wr_valid_in,
    output logic                   wr_ready_out,
    input  logic [ADDR_W-1:0]      wr_addr_in,
    input  logic [PIXEL_WIDTH-1:0] wr_pixel_in,
    input  logic                   wr_last_in,
    input  logic [10:0]            hcount_in,
    input  logic [9:0]             vcount_in,
    input  logic                   video_last_pixel_in,
    output logic [23:0]            rgb_out,
    output logic                   swap_out,
    output logic [15:0]            repeat_count_out,
    output logic                   wr_oob_out
);
    fb_state_e state;
    logic      sel, shown;
    logic      accept, in_range;

    assign accept   = wr_valid_in & wr_ready_out;
    assign in_range = 32'(wr_addr_in) < 32'(DEPTH);

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state            <= FILL;
            sel              <= 1'b0;
            shown            <= 1'b0;
            wr_ready_out     <= 1'b1;
            swap_out         <= 1'b0;
            repeat_count_out <= '0;
            wr_oob_out       <= 1'b0;
        end else begin
            swap_out <= 1'b0;
            if (accept && !in_range) wr_oob_out <= 1'b1;
            // A frame end seen while still filling means the old frame is shown again.
            if (video_last_pixel_in && state == FILL && repeat_count_out != 16'hFFFF)
                repeat_count_out <= repeat_count_out + 16'd1;
            case (state)
                FILL: if (accept && wr_last_in) begin
                    state        <= DONE;
                    wr_ready_out <= 1'b0;
                end
                DONE: if (video_last_pixel_in) begin
                    state        <= FILL;
                    sel          <= ~sel;
                    shown        <= 1'b1;
                    wr_ready_out <= 1'b1;
                    swap_out     <= 1'b1;
                end
                default: state <= FILL;
            endcase
        end
    end

    logic [ADDR_W-1:0] rd_addr;
    logic              rd_active, rd_buf;

    fb_read_addr_gen #(
        .SCREEN_WIDTH (SCREEN_WIDTH),
        .SCREEN_HEIGHT(SCREEN_HEIGHT),
        .SCALE_SHIFT  (SCALE_SHIFT),
        .ADDR_W       (ADDR_W)
    ) u_addr_gen (
        .pixel_clk_in(pixel_clk_in),
        .rst_in      (rst_in),
        .hcount_in   (hcount_in),
        .vcount_in   (vcount_in),
        .sel         (sel),
        .shown       (shown),
        .rd_addr     (rd_addr),
        .rd_active   (rd_active),
        .rd_buf      (rd_buf)
    );

    logic [1:0][PIXEL_WIDTH-1:0] dout;

    // Only an actual write steals a buffer's port, so pixels in flight across a swap still read.
    for (genvar b = 0; b < 2; b++) begin : g_buf
        logic              we;
        logic [ADDR_W-1:0] addr;
        assign we   = accept & in_range & (sel == 1'(b));
        assign addr = we ? wr_addr_in : rd_addr;

        xilinx_single_port_ram_read_first #(
            .RAM_WIDTH      (PIXEL_WIDTH),
            .RAM_DEPTH      (DEPTH),
            .RAM_PERFORMANCE("HIGH_PERFORMANCE")
        ) u_ram (
            .addra (addr),
            .dina  (wr_pixel_in),
            .clka  (pixel_clk_in),
            .wea   (we),
            .ena   (1'b1),
            .rsta  (rst_in),
            .regcea(1'b1),
            .douta (dout[b])
        );
    end

    logic [READ_LATENCY-1:1] vld_pipe, buf_pipe;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            vld_pipe <= '0;
            buf_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[READ_LATENCY-2:1], rd_active};
            buf_pipe <= {buf_pipe[READ_LATENCY-2:1], rd_buf};
        end
    end

    logic [PIXEL_WIDTH-1:0] pix;
    logic [23:0]            rgb_c;

    assign pix = dout[buf_pipe[READ_LATENCY-1]];

    generate
        if (PIXEL_WIDTH == 16) begin : g_rgb565
            assign rgb_c = rgb565_to_rgb888(pix);
        end else begin : g_grey
            assign rgb_c = {3{pix[PIXEL_WIDTH-1 -: 8]}};
        end
    endgenerate

    assign rgb_out = vld_pipe[READ_LATENCY-1] ? rgb_c : 24'h0;
endmodule
